// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes and datapath select codes.
// Pure declarations; no timing or handshake behaviour lives here.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decoder.sv
// Combinational control-word decode from the current state; zero latency.
// Only FETCH (mem_ready) and BRANCH (zero) outputs depend on anything besides state.
module mips_ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      // Request qualifiers depend on state alone, so they hold steady across a stall.
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: lw 5, sw/R/addi 4, beq/j 3 cycles with memory ready.
// FETCH, MEM_RD and MEM_WR hold until mem_ready; reset returns to START asynchronously.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t cur_state;
  state_t nxt_state;
  logic   illegal_c;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_START;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_START;
    illegal_c = 1'b0;
    case (cur_state)
      S_START:  nxt_state = run ? S_FETCH : S_START;
      S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt_state = S_R_EXEC;
          OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
          OP_ADDI:      nxt_state = S_ADDI_EXEC;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_J:         nxt_state = S_JUMP;
          default: begin
            nxt_state = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      // The IR cannot change after DECODE, so only lw/sw reach here; anything else refetches.
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      nxt_state = S_MEM_RD;
        else if (opcode == OP_SW) nxt_state = S_MEM_WR;
        else                      nxt_state = S_FETCH;
      end
      S_MEM_RD:    nxt_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    nxt_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_MEM_WB:    nxt_state = S_FETCH;
      S_R_EXEC:    nxt_state = S_R_WB;
      S_R_WB:      nxt_state = S_FETCH;
      S_ADDI_EXEC: nxt_state = S_ADDI_WB;
      S_ADDI_WB:   nxt_state = S_FETCH;
      S_BRANCH:    nxt_state = S_FETCH;
      S_JUMP:      nxt_state = S_FETCH;
      default:     nxt_state = S_START;
    endcase
  end

  mips_ctrl_decoder u_decoder (
    .state     (cur_state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign pc_en      = ctrl.pc_en;
  assign illegal    = illegal_c;
  assign state      = STATE_W'(cur_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: each row is one cycle of inputs and the outputs expected in it.
// Expected words go through a scoreboard queue; reset corners are driven by hand.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    obs_t       exp;
  } vec_t;

  localparam obs_t O_START      = '{st: S_START, default: '0};
  localparam obs_t O_FETCH_WAIT = '{st: S_FETCH, mem_req: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam obs_t O_FETCH_GO   = '{st: S_FETCH, mem_req: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_en: 1'b1, default: '0};
  localparam obs_t O_DECODE     = '{st: S_DECODE, alu_src_b: 2'b11, default: '0};
  localparam obs_t O_DECODE_ILL = '{st: S_DECODE, alu_src_b: 2'b11, illegal: 1'b1, default: '0};
  localparam obs_t O_MADDR      = '{st: S_MEM_ADDR, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam obs_t O_MRD        = '{st: S_MEM_RD, mem_req: 1'b1, iord: 1'b1, default: '0};
  localparam obs_t O_MWR        = '{st: S_MEM_WR, mem_req: 1'b1, mem_we: 1'b1, iord: 1'b1, default: '0};
  localparam obs_t O_MWB        = '{st: S_MEM_WB, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
  localparam obs_t O_REXEC      = '{st: S_R_EXEC, alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam obs_t O_RWB        = '{st: S_R_WB, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
  localparam obs_t O_AEXEC      = '{st: S_ADDI_EXEC, alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam obs_t O_AWB        = '{st: S_ADDI_WB, reg_write: 1'b1, default: '0};
  localparam obs_t O_BR_T       = '{st: S_BRANCH, alu_src_a: 1'b1, alu_op: 2'b01, pc_source: 2'b01, pc_en: 1'b1, default: '0};
  localparam obs_t O_BR_NT      = '{st: S_BRANCH, alu_src_a: 1'b1, alu_op: 2'b01, pc_source: 2'b01, default: '0};
  localparam obs_t O_JUMP       = '{st: S_JUMP, pc_source: 2'b10, pc_en: 1'b1, default: '0};

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       pc_en, illegal;
  logic [3:0] state;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t sb[$];
  vec_t vecs[$];

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .illegal    (illegal),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr, input obs_t e);
    vec_t v;
    v.run = r; v.opcode = op; v.zero = z; v.mem_ready = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic compare(input string tag);
    obs_t got;
    obs_t exp;
    got = {state, mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, pc_en, illegal};
    exp = sb.pop_front();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h (state %0d) want %h (state %0d)", tag, got, got.st, exp, exp.st);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    run = v.run; opcode = v.opcode; zero = v.zero; mem_ready = v.mem_ready;
    sb.push_back(v.exp);
    @(negedge clk);
    compare(tag);
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr, input obs_t e, input string tag);
    vec_t v;
    v.run = r; v.opcode = op; v.zero = 1'b0; v.mem_ready = mr; v.exp = e;
    apply(v, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

    // START idles until run, then R-type
    add(0, 6'b000000, 0, 1, O_START);
    add(0, 6'b000000, 0, 1, O_START);
    add(1, 6'b000000, 0, 1, O_START);
    add(0, 6'b000000, 0, 1, O_FETCH_GO);
    add(0, 6'b000000, 0, 1, O_DECODE);
    add(0, 6'b000000, 0, 1, O_REXEC);
    add(0, 6'b000000, 0, 1, O_RWB);
    // lw with three stall cycles in MEM_RD
    add(0, 6'b100011, 0, 1, O_FETCH_GO);
    add(0, 6'b100011, 0, 1, O_DECODE);
    add(0, 6'b100011, 0, 1, O_MADDR);
    add(0, 6'b100011, 0, 0, O_MRD);
    add(0, 6'b100011, 0, 0, O_MRD);
    add(0, 6'b100011, 0, 0, O_MRD);
    add(0, 6'b100011, 0, 1, O_MRD);
    add(0, 6'b100011, 0, 1, O_MWB);
    // beq taken, then not taken after a fetch stall
    add(0, 6'b000100, 1, 1, O_FETCH_GO);
    add(0, 6'b000100, 1, 1, O_DECODE);
    add(0, 6'b000100, 1, 1, O_BR_T);
    add(0, 6'b000100, 0, 0, O_FETCH_WAIT);
    add(0, 6'b000100, 0, 1, O_FETCH_GO);
    add(0, 6'b000100, 0, 1, O_DECODE);
    add(0, 6'b000100, 0, 1, O_BR_NT);
    // unsupported opcode: one illegal cycle, straight back to FETCH
    add(0, 6'b111111, 0, 1, O_FETCH_GO);
    add(0, 6'b111111, 0, 1, O_DECODE_ILL);
    // addi
    add(0, 6'b001000, 0, 1, O_FETCH_GO);
    add(0, 6'b001000, 0, 1, O_DECODE);
    add(0, 6'b001000, 0, 1, O_AEXEC);
    add(0, 6'b001000, 0, 1, O_AWB);
    // j: FETCH, DECODE, JUMP, then FETCH again
    add(0, 6'b000010, 0, 1, O_FETCH_GO);
    add(0, 6'b000010, 0, 1, O_DECODE);
    add(0, 6'b000010, 0, 1, O_JUMP);
    // sw without stall
    add(0, 6'b101011, 0, 1, O_FETCH_GO);
    add(0, 6'b101011, 0, 1, O_DECODE);
    add(0, 6'b101011, 0, 1, O_MADDR);
    add(0, 6'b101011, 0, 1, O_MWR);

    #2;
    sb.push_back(O_START);
    compare("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // sw stalled in MEM_WR, then reset lands mid-handshake
    step(0, 6'b101011, 1, O_FETCH_GO, "sw2_fetch");
    step(0, 6'b101011, 1, O_DECODE,   "sw2_decode");
    step(0, 6'b101011, 1, O_MADDR,    "sw2_maddr");
    step(0, 6'b101011, 0, O_MWR,      "sw2_wait0");
    step(0, 6'b101011, 0, O_MWR,      "sw2_wait1");
    rst_n = 1'b0;
    #1;
    sb.push_back(O_START);
    compare("rst_in_mem_wr");
    @(posedge clk);
    #1;
    sb.push_back(O_START);
    compare("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step(0, 6'b101011, 1, O_START,    "post_rst_idle0");
    step(0, 6'b101011, 1, O_START,    "post_rst_idle1");
    step(0, 6'b101011, 1, O_START,    "post_rst_idle2");
    step(1, 6'b000000, 1, O_START,    "post_rst_run");
    step(0, 6'b000000, 1, O_FETCH_GO, "post_rst_fetch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state debug port.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  start enable, sampled only in START.
REQ-005 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completion handshake.
REQ-008 mem_req  out  1  memory access request.
REQ-009 mem_we  out  1  write qualifier for mem_req.
REQ-010 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ir_write  out  1  instruction register load.
REQ-012 reg_dst  out  1  select for the 5-bit write-register mux: 0 = rt, 1 = rd.
REQ-013 mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
REQ-014 reg_write  out  1  register file write enable.
REQ-015 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-016 alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-017 alu_op  out  2  00 = add, 01 = sub, 10 = decode funct.
REQ-018 pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-019 pc_en  out  1  PC load enable.
REQ-020 illegal  out  1  one-cycle pulse on an unsupported opcode.
REQ-021 state  out  STATE_W  current state encoding, for debug.

Function
REQ-022 States: START, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP.
REQ-023 START: all outputs are 0; the FSM moves to FETCH when run=1.
REQ-024 FETCH:
- mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- While mem_ready=0, the FSM holds FETCH with ir_write=0 and pc_en=0.
- When mem_ready=1, ir_write=1 and pc_en=1 in that same cycle, and the FSM moves to DECODE.
REQ-025 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADDR
- 001000 -> ADDI_EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- any other opcode -> FETCH, with illegal=1 for that cycle.
REQ-026 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for opcode 100011, MEM_WR for 101011.
REQ-027 MEM_RD: mem_req=1, iord=1. Holds until mem_ready=1, then moves to MEM_WB.
REQ-028 MEM_WR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready=1, then moves to FETCH.
REQ-029 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-030 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state R_WB.
REQ-031 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-032 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDI_WB.
REQ-033 ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-034 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero; next state FETCH.
REQ-035 JUMP: pc_source=10, pc_en=1; next state FETCH.
REQ-036 Any output not listed for a state is 0 in that state.
REQ-037 Outputs are a function of state only, except ir_write and pc_en in FETCH (gated by mem_ready) and pc_en in BRANCH (gated by zero).
REQ-038 Latency with mem_ready high throughout, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-039 mem_req and mem_we remain stable for as long as the FSM waits for mem_ready.
REQ-040 Unused state encodings go to START on the next edge, with all outputs 0.

Reset
REQ-041 rst_n low forces START immediately, without waiting for a clock edge, and all outputs go to 0.
REQ-042 Reset asserted mid-instruction or mid-handshake drops mem_req in the same cycle, and no instruction is completed.
REQ-043 After rst_n rises, the FSM leaves START only on a rising edge where run=1.

Structure
REQ-044 A shared package mips_ctrl_pkg holds the state encodings, the opcode constants, and the alu_src_b, alu_op and pc_source codes.
REQ-045 A single sub-module, mips_ctrl_decoder, is combinational and produces the control outputs from state, mem_ready and zero.
REQ-046 The next-state register and transition logic are implemented in mips_multicycle_ctrl.

Verification
REQ-047 The bench covers these directed scenarios:
- Reset, then run=1 with opcode=000000 and mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=1 only in R_WB.
- opcode=100011, mem_ready held 0 for 3 cycles in MEM_RD -> mem_req=1 and iord=1 stable throughout; MEM_WB follows, with reg_dst=0 and mem_to_reg=1.
- opcode=000100, with zero=1 and then zero=0 -> pc_en=1 and pc_source=01 in BRANCH for the first case, pc_en=0 for the second.
- opcode=111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH, with reg_write never asserted.
- rst_n driven low in MEM_WR with mem_req=1 -> mem_req=0 immediately; state=START; FSM stays in START while run=0.
- opcode=000010 -> pc_source=10 and pc_en=1 in JUMP; 3 cycles from FETCH entry back to FETCH.
